seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 30 +++
 rtl/muldiv_iter.sv | 68 ++++++
 rtl/seq_alu.sv | 156 +++++++++++++++
 tb/tb_seq_alu.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation encodings, FSM states,
// iterative-unit mode encoding and a helper that classifies multi-cycle ops.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;

  // Iterative unit mode: shift-add multiply or restoring divide.
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // MUL/MULHU/DIVU/REMU all live in the 10xx code block.
  function automatic logic is_iter(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply / divide, one step per clock.
//   start    : load load_val into the low half and perform the first step
//   mode     : MODE_MUL (shift-add) or MODE_DIV (restoring subtract)
//   operand  : multiplicand (MUL) or divisor (DIV), held stable by the caller
//   acc      : {high, low}; MUL -> product, DIV -> {remainder, quotient}
//   done     : registered; high once WIDTH steps have completed
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     load_val,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc,
  output logic                 done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic [2*WIDTH-1:0] base;
  logic [2*WIDTH-1:0] nxt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;

  // One iteration; the start cycle steps from the freshly loaded value.
  always_comb begin
    base    = start ? {{WIDTH{1'b0}}, load_val} : acc;
    nxt     = base;
    mul_sum = {1'b0, base[2*WIDTH-1:WIDTH]} + (base[0] ? {1'b0, operand} : '0);
    rem_sh  = base[2*WIDTH-1:WIDTH-1];
    trial   = rem_sh - {1'b0, operand};
    if (mode == MODE_DIV) begin
      // A borrow out of the trial subtraction means the divisor did not fit.
      if (!trial[WIDTH]) nxt = {trial[WIDTH-1:0], base[WIDTH-2:0], 1'b1};
      else               nxt = {base[2*WIDTH-2:0], 1'b0};
    end else begin
      nxt = {mul_sum, base[WIDTH-1:1]};
    end
  end

  // Accumulator and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      acc  <= nxt;
      cnt  <= CNT_W'(1);
      busy <= 1'b1;
      done <= (CNT_W'(1) == CNT_MAX);
    end else if (busy && (cnt != CNT_MAX)) begin
      acc  <= nxt;
      cnt  <= cnt + CNT_W'(1);
      done <= ((cnt + CNT_W'(1)) == CNT_MAX);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes. Single-cycle ops (ADD, SUB, AND,
// OR, SLT, undefined codes) complete one cycle after acceptance; MUL, MULHU,
// DIVU and REMU run through muldiv_iter and complete WIDTH+1 cycles after.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid / in_ready      : request handshake for A, B, aluControl
//   out_valid / out_ready    : result handshake for result, Z, V, N, C
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       aluControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             Z,
  output logic             V,
  output logic             N,
  output logic             C
);

  state_t             state, state_n;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         op_q;
  logic               accept_c, start_c;

  logic [WIDTH-1:0]   bx_c;
  logic [WIDTH:0]     sum_c;
  logic [WIDTH-1:0]   alu_res_c;
  logic               alu_c_c, alu_v_c;

  logic               md_mode;
  logic [WIDTH-1:0]   md_opnd, md_load;
  logic [2*WIDTH-1:0] md_acc;
  logic               md_done;
  logic [WIDTH-1:0]   md_res_c;

  // Single-cycle datapath, evaluated on the live request inputs.
  always_comb begin
    alu_res_c = '0;
    alu_c_c   = 1'b0;
    alu_v_c   = 1'b0;
    bx_c      = aluControl[0] ? ~B : B;
    sum_c     = {1'b0, A} + {1'b0, bx_c} + (WIDTH+1)'(aluControl[0]);
    case (aluControl)
      OP_ADD, OP_SUB: begin
        alu_res_c = sum_c[WIDTH-1:0];
        alu_c_c   = sum_c[WIDTH];
        alu_v_c   = (sum_c[WIDTH-1] != A[WIDTH-1]) && (A[WIDTH-1] == bx_c[WIDTH-1]);
      end
      OP_AND:  alu_res_c = A & B;
      OP_OR:   alu_res_c = A | B;
      OP_SLT:  alu_res_c = {{(WIDTH-1){1'b0}}, sum_c[WIDTH-1]};
      default: alu_res_c = '0;
    endcase
  end

  // Next-state and handshake decode.
  always_comb begin
    state_n  = state;
    accept_c = 1'b0;
    start_c  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept_c = 1'b1;
          if (is_iter(aluControl)) begin
            start_c = 1'b1;
            state_n = CALC;
          end else begin
            state_n = DONE;
          end
        end
      end
      CALC:    if (md_done) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register; handshake outputs follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
    end
  end

  // On the start cycle the operands are not yet captured, so feed the live inputs.
  assign md_mode  = start_c ? aluControl[1] : op_q[1];
  assign md_opnd  = start_c ? ((aluControl[1] == MODE_DIV) ? B : A)
                            : ((op_q[1] == MODE_DIV) ? b_q : a_q);
  assign md_load  = (aluControl[1] == MODE_DIV) ? A : B;
  // Low/high half select is the same bit for MUL/MULHU and DIVU/REMU.
  assign md_res_c = op_q[0] ? md_acc[2*WIDTH-1:WIDTH] : md_acc[WIDTH-1:0];

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (start_c),
    .mode     (md_mode),
    .load_val (md_load),
    .operand  (md_opnd),
    .acc      (md_acc),
    .done     (md_done)
  );

  // Operand capture and result/flag registers; held steady outside updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      result <= '0;
      Z      <= 1'b0;
      V      <= 1'b0;
      N      <= 1'b0;
      C      <= 1'b0;
    end else begin
      if (accept_c) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= aluControl;
      end
      if (accept_c && !start_c) begin
        result <= alu_res_c;
        Z      <= (alu_res_c == '0);
        N      <= alu_res_c[WIDTH-1];
        C      <= alu_c_c;
        V      <= alu_v_c;
      end else if ((state == CALC) && md_done) begin
        result <= md_res_c;
        Z      <= (md_res_c == '0);
        N      <= md_res_c[WIDTH-1];
        C      <= 1'b0;
        V      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 and WIDTH=8.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        iv, ir, ov, ordy;
  logic [31:0] a, b, res;
  logic [3:0]  ctl;
  logic        z, v, n, c;

  logic        iv8, ir8, ov8, ordy8;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  ctl8;
  logic        z8, v8, n8, c8;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;

  seq_alu #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .A(a), .B(b),
    .aluControl(ctl), .out_valid(ov), .out_ready(ordy), .result(res),
    .Z(z), .V(v), .N(n), .C(c)
  );

  seq_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .aluControl(ctl8), .out_valid(ov8), .out_ready(ordy8), .result(res8),
    .Z(z8), .V(v8), .N(n8), .C(c8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request to the 32-bit DUT and wait for out_valid; lat counts
  // cycles after the accepting edge. Inputs are scrambled after acceptance.
  task automatic issue32(input logic [3:0] op, input logic [31:0] opa,
                         input logic [31:0] opb, output int lat_o);
    int busy_ir;
    @(negedge clk);
    ctl = op; a = opa; b = opb; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0; a = ~opa; b = ~opb; ctl = 4'b0010;
    lat_o = 1; busy_ir = 0;
    while (!ov && lat_o < 100) begin
      if (ir) busy_ir++;
      @(posedge clk); #1;
      lat_o++;
    end
    check("in_ready_low_while_busy", 64'(busy_ir), 64'd0);
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] opa,
                        input logic [7:0] opb, output int lat_o);
    @(negedge clk);
    ctl8 = op; a8 = opa; b8 = opb; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = ~opa; b8 = ~opb;
    lat_o = 1;
    while (!ov8 && lat_o < 100) begin
      @(posedge clk); #1;
      lat_o++;
    end
  endtask

  task automatic consume32;
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check("consume_out_valid", 64'(ov), 64'd0);
    check("consume_in_ready", 64'(ir), 64'd1);
  endtask

  task automatic consume8;
    @(negedge clk);
    ordy8 = 1'b1;
    @(posedge clk); #1;
    ordy8 = 1'b0;
    check("consume8_in_ready", 64'(ir8), 64'd1);
  endtask

  task automatic flags32(input string tag, input logic [3:0] exp_zvnc);
    check(tag, 64'({z, v, n, c}), 64'(exp_zvnc));
  endtask

  initial begin
    rst = 1'b1;
    iv = 1'b0; ordy = 1'b0; a = '0; b = '0; ctl = '0;
    iv8 = 1'b0; ordy8 = 1'b0; a8 = '0; b8 = '0; ctl8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", 64'(res), 64'd0);
    flags32("reset_flags", 4'b0000);
    check("reset_out_valid", 64'(ov), 64'd0);
    check("reset_in_ready", 64'(ir), 64'd1);
    check("reset8_result", 64'(res8), 64'd0);
    check("reset8_in_ready", 64'(ir8), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // ADD signed overflow
    issue32(4'b0000, 32'h7FFF_FFFF, 32'h1, lat);
    check("add_lat", 64'(lat), 64'd1);
    check("add_res", 64'(res), 64'h8000_0000);
    flags32("add_flags", 4'b0110);
    consume32();

    // SUB equal operands
    issue32(4'b0001, 32'd5, 32'd5, lat);
    check("sub_res", 64'(res), 64'd0);
    flags32("sub_flags", 4'b1001);
    consume32();

    // SLT uses the raw sign of A-B
    issue32(4'b0101, 32'hFFFF_FFFF, 32'h1, lat);
    check("slt_res", 64'(res), 64'd1);
    flags32("slt_flags", 4'b0000);
    consume32();

    issue32(4'b0010, 32'hF0F0_1234, 32'h0FF0_FFFF, lat);
    check("and_res", 64'(res), 64'h00F0_1234);
    consume32();

    issue32(4'b0011, 32'hF0F0_1234, 32'h0FF0_FFFF, lat);
    check("or_res", 64'(res), 64'hFFF0_FFFF);
    flags32("or_flags", 4'b0010);
    consume32();

    // Undefined code
    issue32(4'b0111, 32'h1234, 32'h5678, lat);
    check("undef_lat", 64'(lat), 64'd1);
    check("undef_res", 64'(res), 64'd0);
    flags32("undef_flags", 4'b1000);
    consume32();

    issue32(4'b1000, 32'hFFFF_FFFF, 32'd2, lat);
    check("mul_lat", 64'(lat), 64'd33);
    check("mul_res", 64'(res), 64'hFFFF_FFFE);
    flags32("mul_flags", 4'b0010);
    consume32();

    issue32(4'b1001, 32'hFFFF_FFFF, 32'd2, lat);
    check("mulhu_lat", 64'(lat), 64'd33);
    check("mulhu_res", 64'(res), 64'd1);
    consume32();

    issue32(4'b1010, 32'd100, 32'd7, lat);
    check("divu_lat", 64'(lat), 64'd33);
    check("divu_res", 64'(res), 64'd14);
    consume32();

    issue32(4'b1011, 32'd100, 32'd7, lat);
    check("remu_res", 64'(res), 64'd2);
    consume32();

    issue32(4'b1010, 32'd100, 32'd0, lat);
    check("divu0_res", 64'(res), 64'hFFFF_FFFF);
    flags32("divu0_flags", 4'b0010);
    consume32();

    issue32(4'b1011, 32'd100, 32'd0, lat);
    check("remu0_res", 64'(res), 64'd100);
    consume32();

    // Reset at cycle 10 of a DIVU aborts it and clears the held result (100).
    @(negedge clk);
    ctl = 4'b1010; a = 32'd100; b = 32'd7; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 64'(ir), 64'd1);
    check("abort_out_valid", 64'(ov), 64'd0);
    check("abort_result", 64'(res), 64'd0);
    flags32("abort_flags", 4'b0000);
    issue32(4'b0000, 32'd2, 32'd3, lat);
    check("post_abort_lat", 64'(lat), 64'd1);
    check("post_abort_res", 64'(res), 64'd5);
    consume32();

    // Result held under back-pressure while a competing request is presented.
    issue32(4'b0000, 32'hFFFF_FFFF, 32'h1, lat);
    check("hold_res0", 64'(res), 64'd0);
    flags32("hold_flags0", 4'b1001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv = 1'b1; a = 32'd1; b = 32'd2; ctl = 4'b0000;
      @(posedge clk); #1;
      check("hold_out_valid", 64'(ov), 64'd1);
      check("hold_res", 64'(res), 64'd0);
      flags32("hold_flags", 4'b1001);
    end
    // Request still high on the consuming edge must not be taken.
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0; iv = 1'b0;
    check("no_accept_on_consume_ready", 64'(ir), 64'd1);
    @(posedge clk); #1;
    check("no_accept_on_consume_ov", 64'(ov), 64'd0);
    check("no_accept_on_consume_res", 64'(res), 64'd0);

    // WIDTH=8 instance
    issue8(4'b1000, 8'h10, 8'h10, lat);
    check("mul8_lat", 64'(lat), 64'd9);
    check("mul8_res", 64'(res8), 64'h00);
    check("mul8_flags", 64'({z8, v8, n8, c8}), 64'b1000);
    consume8();

    issue8(4'b1001, 8'h10, 8'h10, lat);
    check("mulhu8_res", 64'(res8), 64'h01);
    consume8();

    issue8(4'b1010, 8'd200, 8'd7, lat);
    check("divu8_lat", 64'(lat), 64'd9);
    check("divu8_res", 64'(res8), 64'd28);
    consume8();

    issue8(4'b1011, 8'd200, 8'd7, lat);
    check("remu8_res", 64'(res8), 64'd4);
    consume8();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
